// File: rtl/denise_colortable_ram.sv
// Denise colour lookup table: simple dual-port block RAM, byte-lane writes on
// port A, registered read on port B with a synchronous clear of the output.
module denise_colortable_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NBYTES = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NBYTES-1:0] wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is never touched by rst so the tools can map it onto block RAM.
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Port A: each enabled byte lane overwrites its slice; other lanes are kept.
  always_ff @(posedge clk) begin
    if (ena) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wea[i]) begin
          mem_r[addra][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  // Port B: a read-first output register; rst clears it ahead of enb.
  always_ff @(posedge clk) begin
    if (rst) begin
      doutb <= {DATA_W{1'b0}};
    end else if (enb) begin
      doutb <= mem_r[addrb];
    end
  end

endmodule

// File: tb/tb_denise_colortable_ram.sv
// Directed bench for denise_colortable_ram: reset, byte enables, read-first
// collision, port enables, a full write/read sweep and a write made during reset.
module tb_denise_colortable_ram;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [7:0]  addra;
  logic [31:0] dina;
  logic        enb;
  logic [7:0]  addrb;
  logic [31:0] doutb;

  int n_cmp;
  int n_err;

  denise_colortable_ram dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .enb   (enb),
    .addrb (addrb),
    .doutb (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
    ena   = 1'b1;
    wea   = we;
    addra = a;
    dina  = d;
    tick();
    ena   = 1'b0;
    wea   = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a);
    enb   = 1'b1;
    addrb = a;
    tick();
    enb   = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] held;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    ena   = 1'b0;
    wea   = 4'h0;
    addra = 8'h00;
    dina  = 32'h0;
    enb   = 1'b0;
    addrb = 8'h00;
    tick();
    tick();
    check_eq("reset_state", doutb, 32'h0000_0000);
    rst = 1'b0;

    // Reset clears a nonzero output and keeps it clear; writes still land.
    wr(8'h05, 32'h1234_5678, 4'hF);
    rd(8'h05);
    check_eq("pre_reset_read", doutb, 32'h1234_5678);
    rst   = 1'b1;
    enb   = 1'b1;
    addrb = 8'h05;
    tick();
    check_eq("rst_cycle1", doutb, 32'h0000_0000);
    tick();
    check_eq("rst_cycle2", doutb, 32'h0000_0000);
    enb = 1'b0;
    wr(8'h05, 32'h0ABC_0DEF, 4'hF);
    wr(8'h80, 32'h0000_077F, 4'hF);
    check_eq("rst_hold_during_writes", doutb, 32'h0000_0000);
    rst = 1'b0;
    rd(8'h05);
    check_eq("read_after_rst", doutb, 32'h0ABC_0DEF);
    rd(8'h80);
    check_eq("write_during_rst", doutb, 32'h0000_077F);

    // Byte lanes.
    wr(8'h21, 32'h0FFF_0FFF, 4'hF);
    wr(8'h21, 32'h0123_0456, 4'b0011);
    rd(8'h21);
    check_eq("be_low_half", doutb, 32'h0FFF_0456);
    wr(8'h21, 32'hAA00_0000, 4'b1000);
    rd(8'h21);
    check_eq("be_top_byte", doutb, 32'hAAFF_0456);

    // Same-address read and write in one cycle returns the old word.
    wr(8'h10, 32'h1111_1111, 4'hF);
    ena   = 1'b1;
    wea   = 4'hF;
    addra = 8'h10;
    dina  = 32'h2222_2222;
    enb   = 1'b1;
    addrb = 8'h10;
    tick();
    ena = 1'b0;
    wea = 4'h0;
    check_eq("collision_read_first", doutb, 32'h1111_1111);
    tick();
    check_eq("collision_next_read", doutb, 32'h2222_2222);
    enb = 1'b0;

    // Port enables.
    wr(8'h40, 32'h0000_0000, 4'hF);
    ena   = 1'b0;
    wea   = 4'hF;
    addra = 8'h40;
    dina  = 32'hDEAD_BEEF;
    tick();
    wea = 4'h0;
    rd(8'h40);
    check_eq("ena_low_no_write", doutb, 32'h0000_0000);
    rd(8'h21);
    held  = 32'hAAFF_0456;
    check_eq("enb_setup", doutb, held);
    addrb = 8'h05;
    tick();
    check_eq("enb_low_hold1", doutb, held);
    addrb = 8'h80;
    tick();
    check_eq("enb_low_hold2", doutb, held);
    enb = 1'b1;
    tick();
    check_eq("enb_high_update", doutb, 32'h0000_077F);
    enb = 1'b0;

    // Full sweep: mem[a] = a * 0x01010101, then back-to-back reads.
    for (int a = 0; a < 256; a++) begin
      b = a[7:0];
      wr(b, {b, b, b, b}, 4'hF);
    end
    enb   = 1'b1;
    addrb = 8'h00;
    for (int a = 0; a < 256; a++) begin
      tick();
      b = a[7:0];
      check_eq($sformatf("sweep_%0d", a), doutb, {b, b, b, b});
      addrb = b + 8'h01;
    end
    enb = 1'b0;
    tick();
    check_eq("sweep_last_held", doutb, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
